// File: rtl/gout_monitor.sv
// Change logger for the selevy core's 4-bit general output: every change of
// gout (while enabled) is queued as a {timestamp, value} entry in a show-ahead FIFO.
module gout_monitor #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 12
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      en,
  input  logic [3:0]                gout,
  input  logic                      rd_en,
  output logic [TS_WIDTH+3:0]       rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_WIDTH + 4;
  localparam logic [AW:0]          FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]          CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
  localparam logic [TS_WIDTH-1:0]  TS_ONE     = TS_WIDTH'(1);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [3:0]          gout_q, gout_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ovf_q, ovf_d;

  logic                push, pop, full, wr, drop;

  logic [EW-1:0]       mem [DEPTH];

  always_comb begin
    push     = en && (gout != gout_q);
    pop      = rd_en && rd_valid_q;
    full     = (count_q == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    wr       = push && (!full || pop);
    drop     = push && full && !pop;

    ts_d     = ts_q + TS_ONE;
    gout_d   = gout;
    wr_ptr_d = wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d  = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    rd_valid_d = (count_d != '0);

    // Set has priority over clear so a drop is never lost.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      gout_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      gout_q     <= gout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) begin
      mem[wr_ptr_q] <= {ts_q, gout};
    end
  end

  assign rd_data  = rd_valid_q ? mem[rd_ptr_q] : '0;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
